// File: rtl/aes128_reg_frontend.sv
// AES-128 TinyQV register front end: key/plaintext/result registers and core start/done sequencing.
// Define AES_REG_AUTOSTART_EN to also launch the core on a word write to PT3 while idle.
module aes128_reg_frontend #(
  parameter int unsigned CORE_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   address,
  input  logic [31:0]  data_in,
  input  logic [1:0]   data_write_n,
  input  logic [1:0]   data_read_n,
  output logic [31:0]  data_out,
  output logic         data_ready,
  output logic         user_interrupt,
  output logic [7:0]   uo_out,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_result
);

  // state     | meaning
  // ST_IDLE   | waiting for START
  // ST_LAUNCH | core_start pulse, timeout counter cleared
  // ST_WAIT   | waiting for core_done or timeout
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(CORE_TIMEOUT);
  localparam bit         TO_EN    = (CORE_TIMEOUT != 0);

  state_t            state_q, state_d;
  logic [3:0][31:0]  key_q, key_d;
  logic [3:0][31:0]  pt_q, pt_d;
  logic [3:0][31:0]  ct_q, ct_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rd_prev_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q;

  logic              wr_en, rd_act, rd_fire;
  logic [3:0]        wmask;
  logic [31:0]       wdata;
  logic              idle, busy;
  logic              wr_key, wr_pt, wr_ctrl;
  logic              autostart, start_req;
  logic              done_evt, to_evt;
  logic [31:0]       rword;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign wr_en   = (data_write_n != 2'b11);
  assign rd_act  = (data_read_n != 2'b11);
  assign rd_fire = rd_act && !rd_prev_q;
  assign idle    = (state_q == ST_IDLE);
  assign busy    = !idle;

  // Write data is shifted into the addressed byte lanes.
  always_comb begin
    wmask = 4'b0000;
    wdata = 32'h0;
    case (data_write_n)
      2'b00: begin
        wmask = 4'b0001 << address[1:0];
        wdata = {24'h0, data_in[7:0]} << {address[1:0], 3'b000};
      end
      2'b01: begin
        wmask = address[1] ? 4'b1100 : 4'b0011;
        wdata = address[1] ? {data_in[15:0], 16'h0} : {16'h0, data_in[15:0]};
      end
      2'b10: begin
        wmask = 4'b1111;
        wdata = data_in;
      end
      default: begin
        wmask = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

  assign wr_key  = wr_en && idle && (address[5:4] == 2'b00);
  assign wr_pt   = wr_en && idle && (address[5:4] == 2'b01);
  assign wr_ctrl = wr_en && (address[5:2] == 4'd12) && wmask[0];

`ifdef AES_REG_AUTOSTART_EN
  assign autostart = (data_write_n == 2'b10) && (address == 6'h1C);
`else
  assign autostart = 1'b0;
`endif

  assign start_req = idle && ((wr_ctrl && wdata[0]) || autostart);

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    pt_d       = pt_q;
    ct_d       = ct_q;
    irq_en_d   = irq_en_q;
    irq_d      = irq_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    core_start = 1'b0;
    done_evt   = 1'b0;
    to_evt     = 1'b0;

    if (wr_key) key_d[address[3:2]] = merge(key_q[address[3:2]], wdata, wmask);
    if (wr_pt)  pt_d[address[3:2]]  = merge(pt_q[address[3:2]], wdata, wmask);
    if (wr_ctrl) irq_en_d = wdata[1];

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d   = ST_LAUNCH;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_LAUNCH: begin
        core_start = 1'b1;
        cnt_d      = 8'h00;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // A completion on the same edge as the timeout takes priority.
        if (core_done) begin
          done_evt = 1'b1;
          ct_d     = core_result;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (TO_EN && (cnt_d == TO_LIMIT)) begin
          to_evt    = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((done_evt || to_evt) && irq_en_q) irq_d = 1'b1;
    else if (wr_ctrl && wdata[2])         irq_d = 1'b0;
  end

  // CT is read from its next value so a read coinciding with capture sees the result.
  always_comb begin
    rword = 32'h0;
    case (address[5:4])
      2'b00: rword = key_q[address[3:2]];
      2'b01: rword = pt_q[address[3:2]];
      2'b10: rword = ct_d[address[3:2]];
      2'b11: begin
        if (address[3:2] == 2'd0)      rword = {30'h0, irq_en_q, 1'b0};
        else if (address[3:2] == 2'd1) rword = {28'h0, timeout_q, irq_q, done_q, busy};
        else                           rword = 32'h0;
      end
      default: rword = 32'h0;
    endcase
    rdata_d = rd_fire ? (rword >> {address[1:0], 3'b000}) : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      pt_q      <= '0;
      ct_q      <= '0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 8'h00;
      rd_prev_q <= 1'b0;
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      rd_prev_q <= rd_act;
      rdata_q   <= rdata_d;
      ready_q   <= rd_fire;
    end
  end

  assign data_out       = rdata_q;
  assign data_ready     = ready_q;
  assign user_interrupt = irq_q;
  assign uo_out         = {5'b00000, timeout_q, done_q, busy};
  assign core_key       = key_q;
  assign core_block     = pt_q;

endmodule

// File: tb/tb_aes128_reg_frontend.sv
// Self-checking bench for aes128_reg_frontend: randomized register traffic and core handshakes
// against a register-map level reference model; honours AES_REG_AUTOSTART_EN when defined.
module tb_aes128_reg_frontend;

  logic         clk, rst_n;
  logic [5:0]   address;
  logic [31:0]  data_in;
  logic [1:0]   data_write_n, data_read_n;
  logic [31:0]  data_out;
  logic         data_ready, user_interrupt;
  logic [7:0]   uo_out;
  logic         core_start;
  logic [127:0] core_key, core_block;
  logic         core_done;
  logic [127:0] core_result;

  aes128_reg_frontend #(.CORE_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .user_interrupt(user_interrupt), .uo_out(uo_out),
    .core_start(core_start), .core_key(core_key), .core_block(core_block),
    .core_done(core_done), .core_result(core_result)
  );

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int busy_cnt = 0;
  int s_start, s_busy;
  int cfg_delay = 0;
  logic [127:0] cfg_result = '0;

  logic [31:0] key_m[4], pt_m[4], ct_m[4];
  logic m_irq_en, m_irq, m_done, m_to, m_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_start) start_cnt++;
    if (uo_out[0]) busy_cnt++;
  end

  // Core model: answers cfg_delay cycles after the start pulse; 0 means never.
  initial begin
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start && cfg_delay != 0) begin
        repeat (cfg_delay) @(posedge clk);
        #1 core_done = 1'b1;
        core_result = cfg_result;
        @(posedge clk);
        #1 core_done = 1'b0;
        core_result = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] exp_word(input logic [5:0] a);
    int idx;
    idx = int'(a[5:2]);
    if (idx < 4)       return key_m[idx];
    else if (idx < 8)  return pt_m[idx-4];
    else if (idx < 12) return ct_m[idx-8];
    else if (idx == 12) return {30'h0, m_irq_en, 1'b0};
    else if (idx == 13) return {28'h0, m_to, m_irq, m_done, m_busy};
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      key_m[i] = '0; pt_m[i] = '0; ct_m[i] = '0;
    end
    m_irq_en = 0; m_irq = 0; m_done = 0; m_to = 0; m_busy = 0;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] mode);
    int n, first, idx, lane;
    logic [7:0] b;
    n = 0; first = 0;
    idx = int'(a[5:2]);
    case (mode)
      2'b00: begin n = 1; first = int'(a[1:0]); end
      2'b01: begin n = 2; first = a[1] ? 2 : 0; end
      2'b10: begin n = 4; first = 0; end
      default: n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      lane = first + i;
      b = d[8*i +: 8];
      if (idx < 4 && !m_busy) key_m[idx][8*lane +: 8] = b;
      else if (idx >= 4 && idx < 8 && !m_busy) pt_m[idx-4][8*lane +: 8] = b;
      else if (idx == 12 && lane == 0) begin
        m_irq_en = b[1];
        if (b[2]) m_irq = 0;
      end
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] mode);
    address = a; data_in = d; data_write_n = mode;
    tick();
    data_write_n = 2'b11;
    data_in = $urandom();
    model_write(a, d, mode);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input int hold);
    address = a; data_read_n = 2'b10;
    tick();
    check($sformatf("rd_rdy_%02h", a), data_ready, 1'b1);
    check($sformatf("rd_%02h", a), data_out, exp);
    for (int i = 1; i < hold; i++) begin
      tick();
      check("rd_hold_pulse", data_ready, 1'b0);
    end
    data_read_n = 2'b11;
    tick();
    check("rd_end_pulse", data_ready, 1'b0);
    check("rd_keep", data_out, exp);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (uo_out[0] && n < budget) begin
      tick();
      n++;
    end
    check("idle_wait", uo_out[0], 1'b0);
  endtask

  task automatic start_op(input int delay, input logic [127:0] res, input logic [7:0] ctrl);
    cfg_delay = delay;
    cfg_result = res;
    s_start = start_cnt;
    s_busy = busy_cnt;
    wr(6'h30, {24'h0, ctrl}, 2'b10);
    m_busy = 1; m_done = 0; m_to = 0;
    check("launch_busy", uo_out[0], 1'b1);
  endtask

  task automatic finish_op(input int delay, input logic [127:0] res);
    bit done_ok;
    wait_idle(600);
    done_ok = (delay != 0 && delay <= 255);
    if (done_ok) begin
      m_done = 1;
      for (int i = 0; i < 4; i++) ct_m[i] = res[32*i +: 32];
    end else begin
      m_to = 1;
    end
    if (m_irq_en) m_irq = 1;
    m_busy = 0;
    check("launches", start_cnt - s_start, 1);
    check("busy_len", busy_cnt - s_busy, done_ok ? delay + 1 : 256);
    check("uo_status", uo_out, {5'b0, m_to, m_done, 1'b0});
    check("irq_out", user_interrupt, m_irq);
  endtask

  task automatic rd_block();
    for (int a = 0; a < 48; a += 4) rd(6'(a), exp_word(6'(a)), 1);
    check("core_key", core_key, {key_m[3], key_m[2], key_m[1], key_m[0]});
    check("core_block", core_block, {pt_m[3], pt_m[2], pt_m[1], pt_m[0]});
  endtask

  initial begin
    logic [127:0] kv, pv, cv, r;
    logic [5:0] a;
    logic [1:0] mode;
    int d;

    rst_n = 0; address = 0; data_in = 0; data_write_n = 2'b11; data_read_n = 2'b11;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_uo", uo_out, 8'h00);
    check("rst_irq", user_interrupt, 1'b0);
    check("rst_rdy", data_ready, 1'b0);
    check("rst_start", core_start, 1'b0);
    check("rst_dout", data_out, 32'h0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 16; i++) rd(6'(4*i), 32'h0, (i % 3 == 0) ? 3 : 1);
    check("idle_uo", uo_out, 8'h00);

    wr(6'h02, 32'h000000AB, 2'b00);
    wr(6'h00, 32'h00001234, 2'b01);
    rd(6'h00, 32'h00AB1234, 1);

    for (int i = 0; i < 40; i++) begin
      a = 6'($urandom_range(0, 63));
      if (a[5:2] == 4'd12) a = {2'b00, a[3:0]};
      mode = 2'($urandom_range(0, 2));
      if (mode == 2'b10 && a[5:2] == 4'd7) mode = 2'b00;
      wr(a, $urandom(), mode);
    end
    rd_block();

    kv = 128'h000102030405060708090a0b0c0d0e0f;
    pv = 128'h00112233445566778899aabbccddeeff;
    cv = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int i = 0; i < 4; i++) begin
      wr(6'(4*i), kv[32*i +: 32], 2'b10);
      wr(6'(16 + 4*i), pv[32*i +: 32], 2'b10);
    end
    check("fips_key", core_key, kv);
    check("fips_pt", core_block, pv);
    start_op(20, cv, 8'h03);
    finish_op(20, cv);
    for (int i = 0; i < 4; i++) rd(6'(32 + 4*i), cv[32*i +: 32], 1);
    rd(6'h34, 32'h6, 1);
    wr(6'h30, 32'h4, 2'b10);
    check("irq_clr", user_interrupt, 1'b0);
    rd(6'h34, exp_word(6'h34), 1);

    r = rnd128();
    start_op(30, r, 8'h01);
    repeat (3) tick();
    wr(6'h00, $urandom(), 2'b10);
    wr(6'h14, $urandom(), 2'b10);
    wr(6'h30, 32'h3, 2'b10);
    finish_op(30, r);
    rd(6'h00, exp_word(6'h00), 1);
    rd(6'h14, exp_word(6'h14), 1);
    rd(6'h34, exp_word(6'h34), 1);

    wr(6'h30, 32'h4, 2'b10);
    wr(6'h30, 32'h2, 2'b10);
    r = rnd128();
    start_op(10, r, 8'h03);
    repeat (10) tick();
    wr(6'h30, 32'h6, 2'b10);
    finish_op(10, r);

    r = rnd128();
    start_op(12, r, 8'h01);
    repeat (12) tick();
    address = 6'h20; data_read_n = 2'b10;
    tick();
    check("ct_same_rdy", data_ready, 1'b1);
    check("ct_same_val", data_out, r[31:0]);
    data_read_n = 2'b11;
    tick();
    finish_op(12, r);

    wr(6'h30, 32'h4, 2'b10);
    start_op(0, rnd128(), 8'h01);
    finish_op(0, '0);
    rd(6'h34, 32'h8, 1);
    check("to_pin", uo_out[2], 1'b1);

    r = rnd128();
    start_op(255, r, 8'h01);
    finish_op(255, r);
    rd(6'h34, exp_word(6'h34), 1);
    rd(6'h2C, exp_word(6'h2C), 1);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) wr(6'($urandom_range(0, 6) * 4), $urandom(), 2'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) wr(6'h30, 32'h4, 2'b10);
      d = $urandom_range(1, 40);
      r = rnd128();
      start_op(d, r, 8'(1 | ($urandom_range(0, 1) << 1)));
      finish_op(d, r);
      rd_block();
      rd(6'h30, exp_word(6'h30), 1);
      rd(6'h34, exp_word(6'h34), 1);
    end

    start_op(50, rnd128(), 8'h03);
    repeat (5) tick();
    #2 rst_n = 0;
    #1;
    check("mid_rst_uo", uo_out, 8'h00);
    check("mid_rst_irq", user_interrupt, 1'b0);
    check("mid_rst_start", core_start, 1'b0);
    check("mid_rst_key", core_key, 128'h0);
    check("mid_rst_dout", data_out, 32'h0);
    @(posedge clk);
    #3 rst_n = 1;
    model_reset();
    repeat (60) tick();
    rd(6'h20, 32'h0, 1);
    rd(6'h34, 32'h0, 1);

    d = $urandom();
`ifdef AES_REG_AUTOSTART_EN
    r = rnd128();
    cfg_delay = 5; cfg_result = r;
    s_start = start_cnt; s_busy = busy_cnt;
    wr(6'h1C, d, 2'b10);
    check("auto_start", core_start, 1'b1);
    m_busy = 1; m_done = 0; m_to = 0;
    finish_op(5, r);
    s_start = start_cnt;
    wr(6'h1C, $urandom(), 2'b00);
    check("auto_byte", core_start, 1'b0);
    repeat (3) tick();
    check("auto_byte_cnt", start_cnt - s_start, 0);
`else
    s_start = start_cnt;
    wr(6'h1C, d, 2'b10);
    check("no_auto", core_start, 1'b0);
    repeat (3) tick();
    check("no_auto_cnt", start_cnt - s_start, 0);
`endif
    rd(6'h1C, exp_word(6'h1C), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
